axis_result_fifo: RTL and testbench
===================================

AXIS_RESULT_FIFO -- requirements
Module: axis_result_fifo

Interface
REQ-001 Parameter TDATA_WIDTH, default 64: stream data width in bits.
REQ-002 Parameter TDATA_BYTES, default 8: tkeep width; equals TDATA_WIDTH/8.
REQ-003 Parameter DEPTH, default 16: entry count; power of two, minimum 4.
REQ-004 The clock is s_axis_aclk (input, 1 bit); reset is rst (input, 1 bit), synchronous and active-high.
REQ-005 Input s_axis_tdata, TDATA_WIDTH bits: result data from the upstream adder stage.
REQ-006 Input s_axis_tkeep, TDATA_BYTES bits: byte enables, stored unmodified.
REQ-007 Input s_axis_tlast, 1 bit: end of packet. Input s_axis_tvalid, 1 bit. Output s_axis_tready, 1 bit.
REQ-008 Output m_axis_tdata (TDATA_WIDTH), m_axis_tkeep (TDATA_BYTES), m_axis_tlast (1), m_axis_tvalid (1); input m_axis_tready (1): stream toward DMA S2MM.
REQ-009 Output level, clog2(DEPTH)+1 bits: current occupancy.
REQ-010 Output pkt_done_cnt, 16 bits: count of tlast beats accepted on the master side, wrapping at 16 bits.
REQ-011 Output overflow_sticky, 1 bit: set when s_axis_tvalid is high while the FIFO is full.
REQ-012 Output leds_4bits_tri_o, 4 bits: equals pkt_done_cnt[3:0].

Function
REQ-013 An entry SHALL be {tdata, tkeep, tlast}; a write occurs on an edge with s_axis_tvalid and s_axis_tready both high.
REQ-014 s_axis_tready SHALL be high exactly when level < DEPTH; there is no write-through when full, even if a read occurs in the same cycle.
REQ-015 A read SHALL occur on an edge with m_axis_tvalid and m_axis_tready both high; m_axis_tvalid SHALL be high exactly when level > 0.
REQ-016 The FIFO is first-word-fall-through: m_axis_t* SHALL present the head entry combinationally from storage.
REQ-017 Latency: a beat written into an empty FIFO at edge k SHALL appear on m_axis_t* with m_axis_tvalid high in the cycle after edge k.
REQ-018 m_axis_t* SHALL hold stable while m_axis_tvalid is high and m_axis_tready is low.
REQ-019 Read and write pointers SHALL be clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-020 level SHALL change as follows: +1 on write only, -1 on read only, unchanged on a simultaneous read and write or on neither.
REQ-021 Simultaneous read and write SHALL be legal for 0 < level < DEPTH, including the wrap point.
REQ-022 pkt_done_cnt SHALL increment by 1 on each read whose head tlast is 1, wrapping from 0xFFFF to 0.
REQ-023 overflow_sticky SHALL set on any edge with s_axis_tvalid high and level == DEPTH, and SHALL clear only on reset.
REQ-024 A beat presented while full SHALL NOT be lost; it waits upstream under AXI rules (tready low).

Reset
REQ-025 While rst is high at an edge, the block SHALL set both pointers, level, pkt_done_cnt and overflow_sticky to 0.
REQ-026 After reset: s_axis_tready = 1, m_axis_tvalid = 0, leds_4bits_tri_o = 0.
REQ-027 Reset asserted mid-packet SHALL discard all stored entries; storage contents need not be cleared.
REQ-028 No initial blocks SHALL be relied upon for functional reset.

Structure
REQ-029 A shared package SHALL hold the clog2 function and the default widths (64/8/16).
REQ-030 One sub-module, axis_fifo_ram (simple dual-port, synchronous write, asynchronous read, DEPTH x (TDATA_WIDTH+TDATA_BYTES+1)), SHALL hold storage; pointers, level and counters stay in the top.

Verification
REQ-031 Reset, then write 0x1, 0x2, 0x3 (tlast on 0x3) with m_axis_tready=0 -> level=3, m_axis_tdata=0x1, s_axis_tready=1.
REQ-032 Write 16 beats with m_axis_tready=0 -> level=16, s_axis_tready=0; a 17th tvalid -> overflow_sticky=1 and data unchanged; then drain -> beats 1..16 in order.
REQ-033 Stream 100 beats with tvalid=tready=1 continuously and every 10th beat tlast -> output identical and gap-free after the 1-cycle latency, pkt_done_cnt=10, leds=0xA.
REQ-034 Random tvalid/tready (50%) for 1000 beats across many pointer wraps -> scoreboard match; level never exceeds 16; tkeep (e.g. 0x0F) preserved per beat.
REQ-035 Assert rst for one cycle with level=5 mid-packet -> the next edge gives level=0, m_axis_tvalid=0, pkt_done_cnt=0, overflow_sticky=0.
REQ-036 Preload 0xFFFF packets, then read one more tlast beat -> pkt_done_cnt=0, leds=0x0.

Source files
------------

// File: rtl/axis_result_fifo_pkg.sv
// Shared widths and helpers for the result-stream FIFO.
package axis_result_fifo_pkg;

  localparam int DEF_TDATA_WIDTH = 64;
  localparam int DEF_TDATA_BYTES = 8;
  localparam int DEF_DEPTH       = 16;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module axis_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 73,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_result_fifo.sv
// First-word-fall-through AXI-Stream FIFO between the adder stage and DMA S2MM,
// with packet counting and a sticky overflow flag.
module axis_result_fifo
  import axis_result_fifo_pkg::*;
#(
  parameter int TDATA_WIDTH = DEF_TDATA_WIDTH,
  parameter int TDATA_BYTES = DEF_TDATA_BYTES,
  parameter int DEPTH       = DEF_DEPTH
) (
  input  logic                     s_axis_aclk,
  input  logic                     rst,
  input  logic [TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [TDATA_BYTES-1:0]   s_axis_tkeep,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [TDATA_BYTES-1:0]   m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [clog2(DEPTH):0]    level,
  output logic [15:0]              pkt_done_cnt,
  output logic                     overflow_sticky,
  output logic [3:0]               leds_4bits_tri_o
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = TDATA_WIDTH + TDATA_BYTES + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [15:0]   pkt_cnt_q, pkt_cnt_d;
  logic          ovf_q, ovf_d;
  logic          wr_en, rd_en, full;
  logic [EW-1:0] wr_entry, rd_entry;

  // Full blocks writes outright, even when a read frees a slot this cycle.
  assign full          = (level_q == LW'(DEPTH));
  assign s_axis_tready = ~full;
  assign m_axis_tvalid = (level_q != '0);
  assign wr_en         = s_axis_tvalid & s_axis_tready;
  assign rd_en         = m_axis_tvalid & m_axis_tready;

  assign wr_entry = {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = rd_entry;

  axis_fifo_ram #(.DEPTH(DEPTH), .WIDTH(EW), .AW(AW)) u_ram (
    .clk   (s_axis_aclk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    pkt_cnt_d = pkt_cnt_q;
    ovf_d     = ovf_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (rd_en && m_axis_tlast) pkt_cnt_d = pkt_cnt_q + 16'd1;
    if (s_axis_tvalid && full) ovf_d = 1'b1;
  end

  always_ff @(posedge s_axis_aclk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      pkt_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      pkt_cnt_q <= pkt_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  assign level            = level_q;
  assign pkt_done_cnt     = pkt_cnt_q;
  assign overflow_sticky  = ovf_q;
  assign leds_4bits_tri_o = pkt_cnt_q[3:0];

endmodule

// File: tb/tb_axis_result_fifo.sv
// Directed and randomized stream checks of axis_result_fifo against a queue model.
module tb_axis_result_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tlast, s_tvalid, s_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tlast, m_tvalid, m_tready;
  logic [4:0]  level;
  logic [15:0] pkt_done_cnt;
  logic        ovf;
  logic [3:0]  leds;

  always #5 clk = ~clk;

  axis_result_fifo dut (
    .s_axis_aclk      (clk),
    .rst              (rst),
    .s_axis_tdata     (s_tdata),
    .s_axis_tkeep     (s_tkeep),
    .s_axis_tlast     (s_tlast),
    .s_axis_tvalid    (s_tvalid),
    .s_axis_tready    (s_tready),
    .m_axis_tdata     (m_tdata),
    .m_axis_tkeep     (m_tkeep),
    .m_axis_tlast     (m_tlast),
    .m_axis_tvalid    (m_tvalid),
    .m_axis_tready    (m_tready),
    .level            (level),
    .pkt_done_cnt     (pkt_done_cnt),
    .overflow_sticky  (ovf),
    .leds_4bits_tri_o (leds)
  );

  int          total = 0;
  int          bad   = 0;
  logic [72:0] mq[$];
  logic [15:0] exp_cnt;
  logic        exp_ovf;
  int          max_lvl;
  int          nwr;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, check against the model mid-cycle, then advance the model.
  task automatic cyc(input logic v, input logic [63:0] d, input logic [7:0] k,
                     input logic l, input logic r);
    logic wr, rd;
    s_tvalid = v; s_tdata = d; s_tkeep = k; s_tlast = l; m_tready = r;
    @(negedge clk);
    chk("s_tready", 128'(s_tready), 128'(mq.size() < 16));
    chk("m_tvalid", 128'(m_tvalid), 128'(mq.size() > 0));
    chk("level",    128'(level),    128'(mq.size()));
    chk("pkt_cnt",  128'(pkt_done_cnt), 128'(exp_cnt));
    chk("leds",     128'(leds),     128'(exp_cnt[3:0]));
    chk("ovf",      128'(ovf),      128'(exp_ovf));
    if (mq.size() > 0) chk("head", 128'({m_tdata, m_tkeep, m_tlast}), 128'(mq[0]));
    if (int'(level) > max_lvl) max_lvl = int'(level);
    wr = v && (mq.size() < 16);
    rd = r && (mq.size() > 0);
    if (v && mq.size() == 16) exp_ovf = 1'b1;
    if (rd) begin
      if (mq[0][0]) exp_cnt = exp_cnt + 16'd1;
      void'(mq.pop_front());
    end
    if (wr) begin
      mq.push_back({d, k, l});
      nwr++;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; s_tvalid = 1'b0; m_tready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete();
    exp_cnt = '0;
    exp_ovf = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (mq.size() > 0 && g < 200) begin
      cyc(1'b0, 64'd0, 8'd0, 1'b0, 1'b1);
      g++;
    end
    chk("drain_empty", 128'(mq.size()), 128'd0);
  endtask

  initial begin
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; m_tready = 1'b0;
    exp_cnt = '0; exp_ovf = 1'b0; max_lvl = 0; nwr = 0;
    @(posedge clk); @(posedge clk); #1;
    do_reset();

    // Reset state
    chk("rst_tready", 128'(s_tready), 128'd1);
    chk("rst_tvalid", 128'(m_tvalid), 128'd0);
    chk("rst_leds",   128'(leds),     128'd0);

    // Three beats, no drain
    cyc(1'b1, 64'h1, 8'hFF, 1'b0, 1'b0);
    cyc(1'b1, 64'h2, 8'hFF, 1'b0, 1'b0);
    cyc(1'b1, 64'h3, 8'hFF, 1'b1, 1'b0);
    s_tvalid = 1'b0;
    chk("t3_level",  128'(level),    128'd3);
    chk("t3_tdata",  128'(m_tdata),  128'h1);
    chk("t3_tready", 128'(s_tready), 128'd1);
    drain();
    chk("t3_cnt", 128'(pkt_done_cnt), 128'd1);

    // Fill, overflow attempt, drain in order
    for (int i = 1; i <= 16; i++) cyc(1'b1, 64'(i), 8'hFF, 1'b0, 1'b0);
    chk("full_level",  128'(level),    128'd16);
    chk("full_tready", 128'(s_tready), 128'd0);
    cyc(1'b1, 64'd17, 8'hFF, 1'b0, 1'b0);
    cyc(1'b1, 64'd17, 8'hFF, 1'b0, 1'b1);
    s_tvalid = 1'b0;
    chk("ovf_set",   128'(ovf),     128'd1);
    chk("ovf_head",  128'(m_tdata), 128'd2);
    chk("ovf_level", 128'(level),   128'd15);
    drain();

    // Reset mid-packet with five beats stored
    for (int i = 0; i < 5; i++) cyc(1'b1, 64'(100 + i), 8'hFF, 1'b0, 1'b0);
    chk("pre_rst_level", 128'(level), 128'd5);
    do_reset();
    chk("mid_rst_level",  128'(level),        128'd0);
    chk("mid_rst_tvalid", 128'(m_tvalid),     128'd0);
    chk("mid_rst_cnt",    128'(pkt_done_cnt), 128'd0);
    chk("mid_rst_ovf",    128'(ovf),          128'd0);
    cyc(1'b0, 64'd0, 8'd0, 1'b0, 1'b1);

    // Continuous 100-beat stream, tlast every 10th beat
    for (int i = 0; i < 100; i++)
      cyc(1'b1, 64'h1000 + 64'(i), 8'hFF, (i % 10) == 9, 1'b1);
    drain();
    chk("stream_cnt",  128'(pkt_done_cnt), 128'd10);
    chk("stream_leds", 128'(leds),         128'hA);

    // Random handshakes across many pointer wraps
    nwr = 0;
    for (int g = 0; g < 20000 && nwr < 1000; g++) begin
      cyc(1'($urandom_range(0, 1)), {$urandom, $urandom},
          ($urandom_range(0, 1) != 0) ? 8'h0F : 8'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    chk("rand_writes", 128'(nwr), 128'd1000);
    drain();
    chk("rand_max_lvl", 128'(max_lvl <= 16), 128'd1);

    // Packet counter wrap
    do_reset();
    for (int i = 0; i < 65535; i++) cyc(1'b1, 64'(i), 8'hFF, 1'b1, 1'b1);
    drain();
    chk("wrap_pre", 128'(pkt_done_cnt), 128'hFFFF);
    cyc(1'b1, 64'hABCD, 8'hFF, 1'b1, 1'b0);
    cyc(1'b0, 64'd0, 8'd0, 1'b0, 1'b1);
    chk("wrap_cnt",  128'(pkt_done_cnt), 128'd0);
    chk("wrap_leds", 128'(leds),         128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
